gpu_job_sequencer: RTL and testbench
====================================

GPU_JOB_SEQUENCER -- requirements
Module: gpu_job_sequencer

Parameters
REQ-001 SHALL have parameters: ADDR_W, default 14, vertex/result memory address width (depth 16384); TIMEOUT, default 255, drain watchdog limit in cycles.

Interface
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; all state cleared while low.
REQ-004 cmd_valid  in  1  job request.
REQ-005 cmd_ready  out  1  high only in IDLE; job accepted when cmd_valid & cmd_ready.
REQ-006 cmd_base  in  ADDR_W  first vertex word address.
REQ-007 cmd_count  in  ADDR_W+1  vertex word count, 0..16384.
REQ-008 abort  in  1  cancel current job.
REQ-009 rd_addr  out  ADDR_W  vertex memory read address.
REQ-010 rd_valid  out  1  vertex data valid at processor input, one cycle after matching rd_addr issue.
REQ-011 proc_out_valid  in  1  transformed word from processor.
REQ-012 wr_en  out  1  result memory write strobe.
REQ-013 wr_addr  out  ADDR_W  result memory write address.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle job-complete pulse.
REQ-016 err  out  1  sticky error flag, cleared on next accepted job.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-018 On accept, SHALL latch cmd_base and eff = cmd_count with bits [1:0] forced to 0, then go to FETCH; eff = 0 goes straight to DONE.
REQ-019 In FETCH, SHALL issue one read per cycle: rd_addr = cmd_base + i (i = 0..eff-1), modulo 2^ADDR_W (wraps 16383 -> 0).
REQ-020 rd_valid SHALL be the issue strobe delayed exactly one cycle (1-cycle RAM read latency).
REQ-021 After the last issue, SHALL go to DRAIN.
REQ-022 Each proc_out_valid SHALL register wr_en = 1 next cycle, with wr_addr = cmd_base + k, where k = returned-word index, modulo 2^ADDR_W.
REQ-023 proc_out_valid is counted in FETCH and DRAIN; proc_out_valid in IDLE or DONE, or beyond eff returns, SHALL be ignored (no wr_en) and set err.
REQ-024 DRAIN -> DONE when returned count = eff, including a return on the entry cycle.
REQ-025 Watchdog SHALL count DRAIN cycles without proc_out_valid, reset on each return; on reaching TIMEOUT: set err, go to DONE.
REQ-026 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-027 abort in FETCH, DRAIN or DONE SHALL take effect next edge: IDLE, rd issue stops, no done pulse, err unchanged; abort in IDLE is ignored.
REQ-028 abort and cmd_valid in the same cycle in IDLE: job accepted, abort ignored.
REQ-029 Returned-word counter SHALL be ADDR_W+1 bits so eff = 16384 completes without overflow.

Reset
REQ-030 While reset is low, SHALL force: state IDLE, cmd_ready 1, busy 0, rd_addr 0, rd_valid 0, wr_en 0, wr_addr 0, done 0, err 0, all counters 0.
REQ-031 Reset asserted mid-job SHALL discard the job; no done pulse after release.
REQ-032 cmd_valid SHALL NOT be accepted on the first edge after reset release (one-cycle settle).

Verification
REQ-033 base 0x0010, count 8, processor echoes rd_valid after 5 cycles -> rd_addr 0x10..0x17 on 8 consecutive cycles, wr_addr 0x10..0x17, one done pulse, err 0.
REQ-034 base 0x3FFE, count 6 -> eff 4, rd_addr 0x3FFE, 0x3FFF, 0x0000, 0x0001; wr_addr same sequence; done once.
REQ-035 count 3 -> eff 0, done pulse 2 cycles after accept, no rd_valid, no wr_en.
REQ-036 count 8, only 7 returns -> done asserted TIMEOUT+1 cycles after last return, err 1; err clears on next accept.
REQ-037 abort on 3rd FETCH cycle -> exactly 3 rd_addr issued, IDLE next cycle, cmd_ready 1, no done.
REQ-038 reset pulled low mid-DRAIN -> all outputs at REQ-030 values asynchronously; no done after release.

Source files
------------

// File: rtl/gpu_job_sequencer.sv
// Vertex job sequencer: streams cmd_count (rounded down to a multiple of 4) reads from cmd_base
// and writes each processor return back to the same relative address, with a drain watchdog.
module gpu_job_sequencer #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              proc_out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // wd_q holds cycles since the last return, counting the return cycle as 1, so the
  // done pulse lands TIMEOUT+1 cycles after the last return
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT < 2) ? '0 : WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              settle_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   eff_q;
  logic [ADDR_W:0]   issue_cnt_q;
  logic [ADDR_W:0]   ret_cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WD_W-1:0]   wd_q;

  logic              in_job;
  logic              accept;
  logic              kill;
  logic              ret_hit;
  logic              stray;
  logic [ADDR_W:0]   eff_cmd;
  logic [ADDR_W:0]   issue_d;
  logic [ADDR_W:0]   ret_cnt_d;

  always_comb begin
    in_job    = (state_q == FETCH) || (state_q == DRAIN);
    accept    = cmd_valid && (state_q == IDLE) && settle_q;
    kill      = abort && (state_q != IDLE);
    ret_hit   = proc_out_valid && in_job && !abort && (ret_cnt_q != eff_q);
    stray     = proc_out_valid && !kill && !ret_hit;
    eff_cmd   = cmd_count & {{(ADDR_W-1){1'b1}}, 2'b00};
    issue_d   = issue_cnt_q + 1'b1;
    ret_cnt_d = ret_cnt_q + {{ADDR_W{1'b0}}, ret_hit};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      settle_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      eff_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      rd_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wd_q        <= '0;
    end else begin
      settle_q   <= 1'b1;
      rd_valid_q <= (state_q == FETCH);
      wr_en_q    <= ret_hit;
      // registering done off the DONE state lets an abort in DONE suppress the pulse
      done_q     <= (state_q == DONE) && !abort;

      if (ret_hit) begin
        wr_addr_q <= base_q + ret_cnt_q[ADDR_W-1:0];
        ret_cnt_q <= ret_cnt_d;
      end
      if (stray) begin
        err_q <= 1'b1;
      end

      if (kill) begin
        state_q     <= IDLE;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              base_q      <= cmd_base;
              eff_q       <= eff_cmd;
              rd_addr_q   <= cmd_base;
              issue_cnt_q <= '0;
              ret_cnt_q   <= '0;
              wd_q        <= WD_W'(1);
              err_q       <= stray;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= (eff_cmd == '0) ? DONE : FETCH;
            end
          end
          FETCH: begin
            rd_addr_q   <= rd_addr_q + 1'b1;
            issue_cnt_q <= issue_d;
            wd_q        <= WD_W'(1);
            if (issue_d == eff_q) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (ret_cnt_d == eff_q) begin
              state_q <= DONE;
            end else if (ret_hit) begin
              wd_q <= WD_W'(1);
            end else if (wd_q >= WD_LAST) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          DONE: begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_addr   = rd_addr_q;
  assign rd_valid  = rd_valid_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_gpu_job_sequencer.sv
// Scoreboard bench for gpu_job_sequencer: a 5-cycle echo processor model feeds returns back,
// expected read/write addresses are queued at job start and popped as the DUT produces them.
module tb_gpu_job_sequencer;

  localparam int AW  = 14;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_count = '0;
  logic          cmd_ready, rd_valid, wr_en, busy, done, err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          proc_out_valid;
  logic          echo = 1'b0;
  logic          inject = 1'b0;

  int n_vec = 0, n_bad = 0, cyc = 0;
  int n_done = 0, n_rd = 0, n_wr = 0;
  int done_cyc = 0, last_ret_cyc = 0, acc_cyc = 0;
  int ret_allow = 0, ret_emitted = 0;
  int rd0 = 0, wr0 = 0, done0 = 0;
  logic [AW-1:0] rd_exp[$];
  logic [AW-1:0] wr_exp[$];
  logic [AW-1:0] last_rd_addr = '0;
  logic [5:0]    pipe = '0;

  assign proc_out_valid = echo | inject;

  gpu_job_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .abort(abort),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .proc_out_valid(proc_out_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor and processor model; rd_addr is captured on the issue cycle and checked when rd_valid follows
  always @(negedge clk) begin
    if (!reset) begin
      pipe = '0;
      echo = 1'b0;
    end else begin
      if (rd_valid) begin
        n_rd++;
        if (rd_exp.size() == 0) chk("rd_extra", 32'(rd_valid), 32'd0);
        else chk("rd_addr", 32'(last_rd_addr), 32'(rd_exp.pop_front()));
      end
      if (wr_en) begin
        n_wr++;
        if (wr_exp.size() == 0) chk("wr_extra", 32'(wr_en), 32'd0);
        else chk("wr_addr", 32'(wr_addr), 32'(wr_exp.pop_front()));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      last_rd_addr = rd_addr;
      pipe = {pipe[4:0], rd_valid};
      if (pipe[5] && ret_emitted < ret_allow) begin
        echo = 1'b1;
        ret_emitted++;
        last_ret_cyc = cyc;
      end else begin
        echo = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic prep(input logic [AW-1:0] b, input logic [AW:0] c, input int allow, input int n_iss);
    int eff, iss, nret;
    eff  = int'(c) & ~3;
    iss  = (n_iss < 0) ? eff : n_iss;
    nret = (allow < eff) ? allow : eff;
    for (int i = 0; i < iss; i++) rd_exp.push_back(b + AW'(i));
    for (int k = 0; k < nret; k++) wr_exp.push_back(b + AW'(k));
    ret_allow = allow;
    ret_emitted = 0;
    rd0 = n_rd;
    wr0 = n_wr;
    done0 = n_done;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [AW:0] c, input logic with_abort);
    cmd_valid = 1'b1;
    cmd_base  = b;
    cmd_count = c;
    abort     = with_abort;
    acc_cyc   = cyc;
    tick();
    chk("accept_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && n_done == done0; i++) tick();
    if (n_done == done0) chk("done_timeout", 32'(n_done - done0), 32'd1);
    repeat (3) tick();
  endtask

  task automatic end_job(input string tag, input int exp_rd, input int exp_wr, input logic exp_err);
    chk({tag, "_rd_cnt"}, 32'(n_rd - rd0), 32'(exp_rd));
    chk({tag, "_wr_cnt"}, 32'(n_wr - wr0), 32'(exp_wr));
    chk({tag, "_done_cnt"}, 32'(n_done - done0), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rd_left"}, 32'(rd_exp.size()), 32'd0);
    chk({tag, "_wr_left"}, 32'(wr_exp.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation bound reached");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) tick();
    chk_reset_vals("rst");

    // Job 1 presented on reset release: first edge is the settle edge, accept on the second
    prep(14'h0010, 15'd8, 99, -1);
    cmd_valid = 1'b1;
    cmd_base  = 14'h0010;
    cmd_count = 15'd8;
    reset     = 1'b1;
    tick();
    chk("settle_hold", 32'(busy), 32'd0);
    acc_cyc = cyc;
    tick();
    chk("accept_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    wait_done();
    end_job("j1", 8, 8, 1'b0);

    // Address wrap at the top of memory, count rounded down to 4
    prep(14'h3FFE, 15'd6, 99, -1);
    start(14'h3FFE, 15'd6, 1'b0);
    wait_done();
    end_job("j2", 4, 4, 1'b0);

    // eff = 0: straight to DONE, done two cycles after the accept cycle
    prep(14'h0020, 15'd3, 99, -1);
    start(14'h0020, 15'd3, 1'b0);
    wait_done();
    chk("eff0_done_gap", 32'(done_cyc - acc_cyc), 32'd2);
    end_job("j3", 0, 0, 1'b0);

    // One return missing: watchdog fires TIMEOUT+1 cycles after the last return
    prep(14'h0040, 15'd8, 7, -1);
    start(14'h0040, 15'd8, 1'b0);
    wait_done();
    chk("wd_done_gap", 32'(done_cyc - last_ret_cyc), 32'(TMO + 1));
    end_job("j4", 8, 7, 1'b1);

    // Accept with a simultaneous abort in IDLE; err must clear on accept
    prep(14'h0100, 15'd5, 99, -1);
    start(14'h0100, 15'd5, 1'b1);
    chk("err_clear", 32'(err), 32'd0);
    wait_done();
    end_job("j5", 4, 4, 1'b0);

    // Stray return in IDLE: err set, no write
    wr0 = n_wr;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (2) tick();
    chk("stray_err", 32'(err), 32'd1);
    chk("stray_no_wr", 32'(n_wr - wr0), 32'd0);

    // Abort on the 3rd FETCH cycle
    prep(14'h0200, 15'd16, 0, 3);
    start(14'h0200, 15'd16, 1'b0);
    chk("abort_job_err_clear", 32'(err), 32'd0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("abort_rd_cnt", 32'(n_rd - rd0), 32'd3);
    chk("abort_no_done", 32'(n_done - done0), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_rd_left", 32'(rd_exp.size()), 32'd0);

    // Reset mid-DRAIN: outputs clear asynchronously, job is discarded
    prep(14'h0300, 15'd16, 99, -1);
    start(14'h0300, 15'd16, 1'b0);
    repeat (17) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    rd_exp.delete();
    wr_exp.delete();
    done0 = n_done;
    wr0 = n_wr;
    tick();
    tick();
    reset = 1'b1;
    repeat (30) tick();
    chk("post_rst_no_done", 32'(n_done - done0), 32'd0);
    chk("post_rst_no_wr", 32'(n_wr - wr0), 32'd0);
    chk("post_rst_idle", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
